// File: rtl/prefetch_queue.sv
// Instruction prefetch queue: issues sequential memory reads ahead of the consumer
// and buffers returned words with their addresses in a small in-order queue.
`timescale 1ns/1ps
module prefetch_queue #(
    parameter int DEPTH        = 4,
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_INFLIGHT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       flush,
    input  logic [ADDR_W-1:0]          flush_pc,
    output logic                       mem_rd_en,
    output logic [ADDR_W-1:0]          mem_rd_addr,
    input  logic                       mem_rd_valid,
    input  logic [DATA_W-1:0]          mem_rd_data,
    output logic                       instr_valid,
    output logic [DATA_W-1:0]          instr_word,
    output logic [ADDR_W-1:0]          instr_pc,
    input  logic                       instr_ready,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [ADDR_W-1:0]          fetch_pc
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);
    localparam int SW = CW + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];

    logic [PW-1:0]     head_reg, tail_reg;
    logic [CW-1:0]     count_reg;
    logic [IW-1:0]     inflight_reg;
    logic [IW-1:0]     inflight_ret;
    logic [ADDR_W-1:0] fetch_pc_reg;
    logic [ADDR_W-1:0] ret_addr;
    logic [SW-1:0]     occupancy;
    logic              ret, issue, push, pop;

    always_comb begin
        ret          = mem_rd_valid && (inflight_reg != '0);
        inflight_ret = inflight_reg - IW'(ret);
        occupancy    = SW'(count_reg) + SW'(inflight_reg);
        // Reads return in order and addresses are sequential, so the oldest
        // outstanding read is always fetch_pc minus the number still in flight.
        ret_addr     = fetch_pc_reg - ADDR_W'(inflight_reg);
        // The returning read frees its slot this cycle, which keeps a
        // two-cycle memory streaming at full rate.
        issue        = (state_reg == FETCH) && enable && !flush &&
                       (occupancy < SW'(DEPTH)) &&
                       (inflight_ret < IW'(MAX_INFLIGHT));
        push         = ret && (state_reg != DRAIN) && !flush;
        pop          = (count_reg != '0) && instr_ready && !flush;
    end

    always_comb begin
        state_next = state_reg;
        if (flush) begin
            if (inflight_ret != '0)
                state_next = DRAIN;
            else
                state_next = enable ? FETCH : IDLE;
        end else begin
            unique case (state_reg)
                IDLE:    if (enable) state_next = FETCH;
                FETCH:   if (!enable && inflight_reg == '0) state_next = IDLE;
                DRAIN:   if (inflight_reg == '0) state_next = enable ? FETCH : IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            inflight_reg <= '0;
            fetch_pc_reg <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= inflight_ret + IW'(issue);
            if (flush) begin
                head_reg     <= '0;
                tail_reg     <= '0;
                count_reg    <= '0;
                fetch_pc_reg <= flush_pc;
            end else begin
                if (push)  tail_reg     <= tail_reg + PW'(1);
                if (pop)   head_reg     <= head_reg + PW'(1);
                if (issue) fetch_pc_reg <= fetch_pc_reg + ADDR_W'(1);
                count_reg <= count_reg + CW'(push) - CW'(pop);
            end
        end
    end

    // Entry storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[tail_reg] <= mem_rd_data;
            pc_mem[tail_reg]   <= ret_addr;
        end
    end

    assign mem_rd_en   = issue;
    assign mem_rd_addr = fetch_pc_reg;
    assign instr_valid = (count_reg != '0);
    assign instr_word  = data_mem[head_reg];
    assign instr_pc    = pc_mem[head_reg];
    assign count       = count_reg;
    assign fetch_pc    = fetch_pc_reg;

endmodule

// File: doc/prefetch_queue.md
PREFETCH_QUEUE -- requirements
Module: prefetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, queue entry count (power of two, >= 2).
REQ-002 SHALL have parameter ADDR_W, default 32, instruction address width.
REQ-003 SHALL have parameter DATA_W, default 32, instruction word width.
REQ-004 SHALL have parameter MAX_INFLIGHT, default 2, maximum outstanding memory reads (1..DEPTH).
REQ-005 SHALL have ports:
  clk  in  1  sole clock, all state updates on rising edge
  reset  in  1  asynchronous, active-high
  enable  in  1  permits issuing new reads
  flush  in  1  discard queue and in-flight reads, restart fetch
  flush_pc  in  ADDR_W  new fetch address, sampled when flush=1
  mem_rd_en  out  1  one-cycle read request
  mem_rd_addr  out  ADDR_W  read address, valid with mem_rd_en
  mem_rd_valid  in  1  read data returning, in request order
  mem_rd_data  in  DATA_W  returned instruction word
  instr_valid  out  1  queue head valid
  instr_word  out  DATA_W  queue head word
  instr_pc  out  ADDR_W  address of queue head word
  instr_ready  in  1  consumer pops head when instr_valid=1
  count  out  $clog2(DEPTH+1)  current occupancy
  fetch_pc  out  ADDR_W  address of next read to issue

Function
REQ-006 SHALL implement FSM states IDLE, FETCH, DRAIN.
REQ-007 IDLE -> FETCH when enable=1 and flush=0; FETCH -> IDLE when enable=0 and inflight=0.
REQ-008 flush=1 in any state SHALL move to DRAIN if inflight (after this cycle's returns) > 0, else to FETCH if enable=1, else IDLE.
REQ-009 DRAIN -> FETCH (or IDLE if enable=0) in the cycle after inflight reaches 0.
REQ-010 In FETCH, a read SHALL issue when count + inflight < DEPTH and inflight < MAX_INFLIGHT; at most one read per cycle.
REQ-011 On issue: mem_rd_en=1, mem_rd_addr=fetch_pc, fetch_pc increments by 1 modulo 2^ADDR_W (wrap all-ones -> 0).
REQ-012 mem_rd_en SHALL be 0 in IDLE and DRAIN and in any cycle with flush=1.
REQ-013 mem_rd_valid in FETCH/IDLE SHALL push {mem_rd_data, its request address} at the tail; in DRAIN it SHALL be discarded.
REQ-014 instr_valid = (count > 0); instr_word/instr_pc SHALL be combinational from the head entry.
REQ-015 Pop occurs when instr_valid=1 and instr_ready=1; pop and push in one cycle SHALL leave count unchanged and both take effect.
REQ-016 Push SHALL never find the queue full (guaranteed by REQ-010); a push with count=DEPTH is a verification error, not handled.
REQ-017 Flush priority: flush=1 SHALL suppress pop, push and issue in that cycle; count becomes 0, fetch_pc <= flush_pc, responses arriving that cycle count toward discard.
REQ-018 inflight SHALL increment on issue, decrement on mem_rd_valid, both in one cycle = unchanged; mem_rd_valid with inflight=0 SHALL be ignored.
REQ-019 Latency: first instr_valid SHALL assert the cycle after mem_rd_valid for the first read after reset/flush.
REQ-020 enable deassert SHALL stop issue only; pending returns still push, pops continue.

Reset
REQ-021 While reset=1: state IDLE, count 0, inflight 0, fetch_pc 0, mem_rd_en 0, mem_rd_addr 0, instr_valid 0, queue pointers 0.
REQ-022 Reset asserted mid-operation SHALL abandon all entries and in-flight reads immediately; post-reset responses with inflight=0 are ignored.

Verification
REQ-023 Fill: reset, enable=1, instr_ready=0, memory returns addr^32'h0300_0000 after 2 cycles -> reads at 0,1,2,3 only, count=4, no further mem_rd_en.
REQ-024 Streaming: instr_ready=1 continuous, MAX_INFLIGHT=2, 2-cycle memory -> instr_pc sequence 0,1,2,... with one pop per cycle once primed, no gaps after priming.
REQ-025 Flush with inflight=2: flush=1, flush_pc=32'h100 -> count=0, two responses discarded in DRAIN, next mem_rd_addr=32'h100, first instr_pc=32'h100.
REQ-026 Wrap: flush_pc=32'hFFFF_FFFF -> reads at FFFF_FFFF then 0000_0000, instr_pc follows.
REQ-027 Simultaneous push+pop at count=DEPTH-1 and count=1 -> count unchanged, word order preserved.
REQ-028 Reset asserted with count=3, inflight=1 -> all outputs to REQ-021 values asynchronously; late mem_rd_valid ignored, count stays 0.
